// File: rtl/prism_pattern_gen.sv
// rtl/prism_pattern_gen.sv - VGA timing, frame-prescaled animation and bouncing-centre pattern generator
// Build macro PRISM_STARFIELD_EN selects a starfield instead of black as the mode-01 background.
module prism_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int COLOR_BITS = 2,
  parameter int CNT_W      = 10,
  parameter int DIAMOND_R  = 200,
  parameter int MARGIN     = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic [2:0]            speed,
  input  logic                  freeze,
  input  logic                  bounce_en,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  display_on,
  output logic [COLOR_BITS-1:0] r,
  output logic [COLOR_BITS-1:0] g,
  output logic [COLOR_BITS-1:0] b,
  output logic [CNT_W-1:0]      frame_cnt
);
  localparam int HT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = CNT_W + 2;
  localparam logic [9:0]  HT_M1  = 10'(HT - 1);
  localparam logic [9:0]  VT_M1  = 10'(VT - 1);
  localparam logic [9:0]  HS_ON  = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0]  HS_OFF = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0]  VS_ON  = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0]  VS_OFF = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [9:0]  HA     = 10'(H_ACTIVE);
  localparam logic [9:0]  VA     = 10'(V_ACTIVE);
  localparam logic [9:0]  CX0    = 10'(H_ACTIVE / 2);
  localparam logic [9:0]  CY0    = 10'(V_ACTIVE / 2);
  localparam logic [9:0]  X_HI   = 10'(H_ACTIVE - 1 - MARGIN);
  localparam logic [9:0]  Y_HI   = 10'(V_ACTIVE - 1 - MARGIN);
  localparam logic [9:0]  C_LO   = 10'(MARGIN);
  localparam logic [10:0] DR     = 11'(DIAMOND_R);

  typedef enum logic {DIR_INC, DIR_DEC} dir_e;

  logic [9:0]            hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [2:0]            presc_q, presc_d;
  logic [CNT_W-1:0]      fcnt_q, fcnt_d;
  logic [9:0]            cx_q, cx_d, cy_q, cy_d;
  dir_e                  dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [1:0]            mode_q, mode_d;
  logic                  hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [COLOR_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic                  tick, step;

  logic [9:0]            dx, dy;
  logic [10:0]           s;
  logic [DW-1:0]         d;
  logic [2:0]            bar;
  logic [COLOR_BITS-1:0] dr, dg, db, bg_c;

  assign tick = (hcnt_q == HT_M1) && (vcnt_q == VT_M1);

  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == HT_M1) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == VT_M1) ? '0 : vcnt_q + 10'd1;
    end
  end

  // Mode, prescaler and animation counter only move on the last pixel of a frame.
  always_comb begin
    mode_d  = mode_q;
    presc_d = presc_q;
    fcnt_d  = fcnt_q;
    step    = 1'b0;
    if (tick) begin
      mode_d = mode;
      if (!freeze) begin
        if (presc_q == speed) begin
          presc_d = '0;
          fcnt_d  = fcnt_q + CNT_W'(1);
          step    = 1'b1;
        end else begin
          presc_d = presc_q + 3'd1;
        end
      end
    end
  end

  always_comb begin
    cx_d    = cx_q;
    cy_d    = cy_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    if (step && bounce_en) begin
      if (dir_x_q == DIR_INC) begin
        cx_d = cx_q + 10'd1;
        if (cx_d == X_HI) dir_x_d = DIR_DEC;
      end else begin
        cx_d = cx_q - 10'd1;
        if (cx_d == C_LO) dir_x_d = DIR_INC;
      end
      if (dir_y_q == DIR_INC) begin
        cy_d = cy_q + 10'd1;
        if (cy_d == Y_HI) dir_y_d = DIR_DEC;
      end else begin
        cy_d = cy_q - 10'd1;
        if (cy_d == C_LO) dir_y_d = DIR_INC;
      end
    end
  end

  always_comb begin
    dx  = (hcnt_q >= cx_q) ? hcnt_q - cx_q : cx_q - hcnt_q;
    dy  = (vcnt_q >= cy_q) ? vcnt_q - cy_q : cy_q - vcnt_q;
    s   = {1'b0, dx} + {1'b0, dy};
    d   = DW'(s) + DW'(fcnt_q);
    dr  = COLOR_BITS'(d >> 2);
    dg  = COLOR_BITS'(d >> 4);
    db  = COLOR_BITS'(d >> 6);
    bar = 3'({hcnt_q, 3'b000} / 13'(H_ACTIVE));
  end

`ifdef PRISM_STARFIELD_EN
  logic [7:0] hash;
  always_comb begin
    hash = (hcnt_q[7:0] ^ vcnt_q[7:0] ^ {hcnt_q[3:0], vcnt_q[3:0]}) + fcnt_q[7:0];
    bg_c = (hash[7:3] == 5'd0) ? COLOR_BITS'(2'(hash >> 1)) : '0;
  end
`else
  assign bg_c = '0;
`endif

  // Everything below is computed from the current counters and registered together.
  always_comb begin
    hsync_d = !((hcnt_q >= HS_ON) && (hcnt_q < HS_OFF));
    vsync_d = !((vcnt_q >= VS_ON) && (vcnt_q < VS_OFF));
    de_d    = (hcnt_q < HA) && (vcnt_q < VA);
    r_d     = '0;
    g_d     = '0;
    b_d     = '0;
    if (de_d) begin
      case (mode_q)
        2'b00: begin
          r_d = dr; g_d = dg; b_d = db;
        end
        2'b01: begin
          if (s <= DR) begin
            r_d = dr; g_d = dg; b_d = db;
          end else begin
            r_d = bg_c; g_d = bg_c; b_d = bg_c;
          end
        end
        2'b10: begin
          r_d = {COLOR_BITS{bar[0]}};
          g_d = {COLOR_BITS{bar[1]}};
          b_d = {COLOR_BITS{bar[2]}};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      presc_q <= '0;
      fcnt_q  <= '0;
      cx_q    <= CX0;
      cy_q    <= CY0;
      dir_x_q <= DIR_INC;
      dir_y_q <= DIR_INC;
      mode_q  <= 2'b00;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      presc_q <= presc_d;
      fcnt_q  <= fcnt_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      mode_q  <= mode_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign display_on = de_q;
  assign r          = r_q;
  assign g          = g_q;
  assign b          = b_q;
  assign frame_cnt  = fcnt_q;

endmodule
